// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - W-bit adder built from one 4-bit slice, one nibble per clock (optional ovf via NSA_OVF_EN)
module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
`ifdef NSA_OVF_EN
    output logic         ovf,
`endif
    output logic         co
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  work_q, work_d;
    logic [W-1:0]  s_q, s_d;
    logic          carry_q, carry_d;
    logic          co_q, co_d;
    logic [IW-1:0] idx_q, idx_d;
`ifdef NSA_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [4:0]    slice;
    logic [W-1:0]  work_nxt;

    // Single 4-bit slice plus next-state/datapath update for the FSM
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        s_d      = s_q;
        carry_d  = carry_q;
        co_d     = co_q;
        idx_d    = idx_q;
`ifdef NSA_OVF_EN
        ovf_d    = ovf_q;
`endif
        a_nib    = a_q[4*idx_q +: 4];
        b_nib    = b_q[4*idx_q +: 4];
        slice    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        work_nxt = work_q;
        work_nxt[4*idx_q +: 4] = slice[3:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d  = work_nxt;
                carry_d = slice[4];
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    s_d     = work_nxt;
                    co_d    = slice[4];
`ifdef NSA_OVF_EN
                    // carry into the MSB is recovered from the MSB sum bit and its operand bits
                    ovf_d   = (a_nib[3] ^ b_nib[3] ^ slice[3]) ^ slice[4];
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any add in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            idx_q   <= '0;
`ifdef NSA_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            idx_q   <= idx_d;
`ifdef NSA_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;
`ifdef NSA_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
`ifdef NSA_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
`ifdef NSA_OVF_EN
        .ovf   (ovf),
`endif
        .co    (co)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rep(input logic [63:0] pat);
        logic [63:0] p;
        p = pat;
        return p[W-1:0];
    endfunction

    // full add from a start at the current cycle; expectation from a W+1-bit sum
    task automatic run_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic tci);
        logic [W:0] exp;
        exp = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tci};
        a = ta; b = tb_; ci = tci; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ta; b = ~tb_; ci = ~tci;
        for (int i = 0; i < N; i++) begin
            check({tag, "_busy"}, 128'(busy), 128'(1));
            check({tag, "_nodone"}, 128'(done), 128'(0));
            tick();
        end
        check({tag, "_done"}, 128'(done), 128'(1));
        check({tag, "_idle"}, 128'(busy), 128'(0));
        check({tag, "_s"}, 128'(s), 128'(exp[W-1:0]));
        check({tag, "_co"}, 128'(co), 128'(exp[W]));
`ifdef NSA_OVF_EN
        check({tag, "_ovf"}, 128'(ovf),
              128'((ta[W-1] == tb_[W-1]) && (exp[W-1] != ta[W-1])));
`endif
        tick();
        check({tag, "_pulse"}, 128'(done), 128'(0));
        check({tag, "_hold"}, 128'(s), 128'(exp[W-1:0]));
    endtask

    initial begin
        int dones;
        int pre;
        // reset state
        #3;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_s", 128'(s), 128'(0));
        check("rst_co", 128'(co), 128'(0));
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < N + 3; i++) begin
            tick();
            if (done) dones++;
        end
        check("nostart_done", 128'(dones), 128'(0));

        // main function and carry ripple
        run_add("add_mix", rep(64'h1234123412341234), rep(64'h4321432143214321), 1'b0);
        run_add("ripple", rep(64'hFFFFFFFFFFFFFFFF), '0, 1'b1);
        run_add("ones", rep(64'hFFFFFFFFFFFFFFFF), rep(64'hFFFFFFFFFFFFFFFF), 1'b1);
        run_add("signed_ovf", rep(64'h7FFFFFFFFFFFFFFF), W'(1), 1'b0);
        run_add("wrap", rep(64'hFFFFFFFFFFFFFFFF), W'(1), 1'b0);

        // starts during RUN and DONE are ignored
        a = W'(1); b = W'(1); ci = 1'b0; start = 1'b1;
        tick();                                   // edge k0
        start = 1'b0;
        dones = 0;
        for (int e = 1; e <= N + 1; e++) begin
            // start asserted so it is sampled at edge k0+2 (if still RUN) and in DONE
            if (e == 2 || e == N + 1) begin
                a = rep(64'hAAAAAAAAAAAAAAAA); b = rep(64'h5555555555555555); start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done) dones++;
        end
        check("ign_idle", 128'(busy), 128'(0));
        for (int i = 0; i < N + 2; i++) begin
            tick();
            if (done) dones++;
        end
        check("ign_single_done", 128'(dones), 128'(1));
        check("ign_s", 128'(s), 128'(2));
        check("ign_co", 128'(co), 128'(0));
        run_add("after_ign", W'(3), W'(4), 1'b1);

        // start accepted at k0+N+2 (minimum spacing)
        a = W'(5); b = W'(6); ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N + 1; i++) tick();  // through edge k0+N+1
        a = W'(9); b = W'(9); start = 1'b1;
        tick();                                   // edge k0+N+2
        start = 1'b0;
        check("spacing_busy", 128'(busy), 128'(1));
        for (int i = 0; i < N; i++) tick();
        check("spacing_done", 128'(done), 128'(1));
        check("spacing_s", 128'(s), 128'(18));
        tick();

        // asynchronous reset mid-operation
        a = rep(64'h1111111111111111); b = rep(64'h2222222222222222); ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        pre = (N > 2) ? 2 : N - 1;
        for (int i = 0; i < pre; i++) tick();
        check("midrst_pre_busy", 128'(busy), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        check("midrst_s", 128'(s), 128'(0));
        check("midrst_co", 128'(co), 128'(0));
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < N + 3; i++) begin
            tick();
            if (done) dones++;
        end
        check("midrst_nodone", 128'(dones), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
